mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage, behind the EX/MEM latch.
- Consumes the execute result: the effective address for loads/stores, or the ALU result otherwise. Also consumes store data and the access descriptor.
- Performs loads and stores byte-serially over an 8-bit synchronous RAM port and stalls the pipeline while busy.
- Produces the write-back triple wd_o/wreg_o/wdata_o for MEM/WB.

---
 rtl/mem_stage_if.sv | 42 ++++
 rtl/mem_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the pipeline-side and RAM-side signals of mem_stage.
//   Parameter ADDR_W : RAM byte-address width.
//   Pipeline in  : req_i, we_i, size_i, unsigned_i, wd_i, wreg_i, wdata_i, mem_w_data_i
//   RAM in       : ram_din_i
//   RAM out      : ram_addr_o, ram_dout_o, ram_we_o
//   Pipeline out : stall_req_o, done_o, misalign_o, wd_o, wreg_o, wdata_o
//   modport slave  : the memory stage itself
//   modport master : the surrounding pipeline / RAM that drives the stage
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic [31:0]       wdata_i;
  logic [31:0]       mem_w_data_i;
  logic [7:0]        ram_din_i;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_dout_o;
  logic              ram_we_o;
  logic              stall_req_o;
  logic              done_o;
  logic              misalign_o;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [31:0]       wdata_o;

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, wd_i, wreg_i, wdata_i, mem_w_data_i, ram_din_i,
    output ram_addr_o, ram_dout_o, ram_we_o, stall_req_o, done_o, misalign_o,
           wd_o, wreg_o, wdata_o
  );

  modport master (
    output req_i, we_i, size_i, unsigned_i, wd_i, wreg_i, wdata_i, mem_w_data_i, ram_din_i,
    input  ram_addr_o, ram_dout_o, ram_we_o, stall_req_o, done_o, misalign_o,
           wd_o, wreg_o, wdata_o
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage behind the EX/MEM latch.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : mem_stage_if.slave (pipeline operands, 8-bit sync RAM port,
//         stall/done/misalign status, write-back triple wd_o/wreg_o/wdata_o)
// Loads take N+1 BUSY cycles (RAM read data lags its address by one cycle),
// stores take N BUSY cycles, N = 1/2/4 bytes. stall_req_o, wd_o, wreg_o and
// wdata_o are combinational; all other outputs are registered.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip
// the RAM and retire with misalign_o=1; when undefined misalign_o is tied 0.
module mem_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_we_q, ram_we_d;
  logic              done_q, done_d;

  logic              lat_we_q;
  logic [1:0]        lat_size_q;
  logic              lat_uns_q;
  logic [4:0]        lat_wd_q;
  logic              lat_wreg_q;
  logic [31:0]       lat_sdata_q;

  logic              load_c;
  logic              trap_c;
  logic              mis_now_c;
  logic              stall_c;
  logic [4:0]        wd_c;
  logic              wreg_c;
  logic [31:0]       wdata_c;
  logic [CW-1:0]     nbytes_c;
  logic [CW-1:0]     last_c;
  logic [1:0]        nidx_c;
  logic [1:0]        cidx_c;
  logic [31:0]       ext_c;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  // Half at odd address, or word (size 10/11) not on a 4-byte boundary.
  assign trap_c = (bus.size_i == 2'b01) ? bus.wdata_i[0]
                                        : (bus.size_i[1] && (bus.wdata_i[1:0] != 2'b00));
  assign mis_now_c      = mis_q;
  assign bus.misalign_o = mis_q;
`else
  assign trap_c         = 1'b0;
  assign mis_now_c      = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif

  // Byte count of the latched access and the counter value that ends BUSY.
  always_comb begin
    case (lat_size_q)
      2'b00:   nbytes_c = CW'(1);
      2'b01:   nbytes_c = CW'(2);
      default: nbytes_c = CW'(4);
    endcase
    last_c = lat_we_q ? (nbytes_c - CW'(1)) : nbytes_c;
  end

  // Store byte for the next address; load byte landing this cycle (k-1).
  assign nidx_c = cnt_q[1:0] + 2'd1;
  assign cidx_c = cnt_q[1:0] - 2'd1;

  // Load result extension.
  always_comb begin
    case (lat_size_q)
      2'b00:   ext_c = lat_uns_q ? {24'd0, shreg_q[7:0]}
                                 : {{24{shreg_q[7]}}, shreg_q[7:0]};
      2'b01:   ext_c = lat_uns_q ? {16'd0, shreg_q[15:0]}
                                 : {{16{shreg_q[15]}}, shreg_q[15:0]};
      default: ext_c = shreg_q;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    ram_we_d   = 1'b0;
    done_d     = 1'b0;
    load_c     = 1'b0;
    stall_c    = 1'b0;
    wd_c       = 5'd0;
    wreg_c     = 1'b0;
    wdata_c    = 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          stall_c = 1'b1;
          load_c  = 1'b1;
          cnt_d   = '0;
          shreg_d = '0;
          if (trap_c) begin
            state_d = DONE;
            done_d  = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_d   = 1'b1;
`endif
          end else begin
            state_d    = BUSY;
            ram_addr_d = bus.wdata_i[ADDR_W-1:0];
            ram_we_d   = bus.we_i;
            ram_dout_d = bus.mem_w_data_i[7:0];
          end
        end else begin
          wd_c    = bus.wd_i;
          wreg_c  = bus.wreg_i;
          wdata_c = bus.wdata_i;
        end
      end

      BUSY: begin
        stall_c = 1'b1;
        // Read data for address k-1 arrives while address k is presented.
        if (!lat_we_q && (cnt_q != '0)) begin
          shreg_d[{cidx_c, 3'b000} +: 8] = bus.ram_din_i;
        end
        if (cnt_q == last_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          ram_addr_d = ram_addr_q + ADDR_W'(1);
          ram_we_d   = lat_we_q;
          if (lat_we_q) begin
            ram_dout_d = lat_sdata_q[{nidx_c, 3'b000} +: 8];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        if (!lat_we_q && !mis_now_c) begin
          wd_c    = lat_wd_q;
          wreg_c  = lat_wreg_q;
          wdata_c = ext_c;
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset forces the combinational outputs low as well.
    if (!rst) begin
      stall_c = 1'b0;
      wd_c    = 5'd0;
      wreg_c  = 1'b0;
      wdata_c = 32'd0;
    end
  end

  // State, counter, shift register and registered RAM/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      ram_addr_q <= '0;
      ram_dout_q <= '0;
      ram_we_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      ram_we_q   <= ram_we_d;
      done_q     <= done_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= mis_d;
`endif
    end
  end

  // Operand latch, loaded when an access is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we_q    <= 1'b0;
      lat_size_q  <= 2'b00;
      lat_uns_q   <= 1'b0;
      lat_wd_q    <= 5'd0;
      lat_wreg_q  <= 1'b0;
      lat_sdata_q <= 32'd0;
    end else if (load_c) begin
      lat_we_q    <= bus.we_i;
      lat_size_q  <= bus.size_i;
      lat_uns_q   <= bus.unsigned_i;
      lat_wd_q    <= bus.wd_i;
      lat_wreg_q  <= bus.wreg_i;
      lat_sdata_q <= bus.mem_w_data_i;
    end
  end

  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_dout_o  = ram_dout_q;
  assign bus.ram_we_o    = ram_we_q;
  assign bus.done_o      = done_q;
  assign bus.stall_req_o = stall_c;
  assign bus.wd_o        = wd_c;
  assign bus.wreg_o      = wreg_c;
  assign bus.wdata_o     = wdata_c;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with a small
// 8-bit synchronous RAM model (4 KiB, indexed by the low 12 address bits).
// Expected values for the misalignment cases follow MEM_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module tb_mem_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_stage_if #(.ADDR_W(32)) bus ();

  mem_stage #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write on strobe, read data one cycle after its address.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_addr_o[11:0]] <= bus.ram_dout_o;
    bus.ram_din_i <= mem[bus.ram_addr_o[11:0]];
  end

  // Results of the most recent access.
  logic [39:0] wlog [$];
  int          stalls;
  logic        seen_done;
  logic [31:0] d_wdata;
  logic [4:0]  d_wd;
  logic        d_wreg;
  logic        d_mis;
  logic        d_stall;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one access, count stall cycles, record writes, capture DONE outputs.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [4:0] wd, input logic [31:0] addr,
                        input logic [31:0] sdata);
    bus.req_i        = 1'b1;
    bus.we_i         = we;
    bus.size_i       = size;
    bus.unsigned_i   = uns;
    bus.wd_i         = wd;
    bus.wreg_i       = 1'b1;
    bus.wdata_i      = addr;
    bus.mem_w_data_i = sdata;
    wlog.delete();
    stalls    = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      #1;
      if (bus.ram_we_o) wlog.push_back({bus.ram_addr_o, bus.ram_dout_o});
      if (bus.done_o) begin
        seen_done = 1'b1;
        d_wdata   = bus.wdata_o;
        d_wd      = bus.wd_o;
        d_wreg    = bus.wreg_o;
        d_mis     = bus.misalign_o;
        d_stall   = bus.stall_req_o;
      end else begin
        if (bus.stall_req_o) stalls++;
        step();
      end
    end
    check("done_seen", 32'(seen_done), 32'd1);
    step();
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.wd_i    = 5'd0;
    bus.wreg_i  = 1'b0;
    bus.wdata_i = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [39:0] e;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.req_i        = 1'b1;
    bus.we_i         = 1'b0;
    bus.size_i       = 2'b10;
    bus.unsigned_i   = 1'b0;
    bus.wd_i         = 5'd7;
    bus.wreg_i       = 1'b1;
    bus.wdata_i      = 32'h55;
    bus.mem_w_data_i = 32'd0;

    // Reset: outputs low even with live inputs.
    repeat (3) step();
    #1;
    check("rst_stall", 32'(bus.stall_req_o), 32'd0);
    check("rst_wd",    32'(bus.wd_o),        32'd0);
    check("rst_wreg",  32'(bus.wreg_o),      32'd0);
    check("rst_wdata", bus.wdata_o,          32'd0);
    check("rst_we",    32'(bus.ram_we_o),    32'd0);
    check("rst_addr",  bus.ram_addr_o,       32'd0);
    check("rst_done",  32'(bus.done_o),      32'd0);
    check("rst_mis",   32'(bus.misalign_o),  32'd0);
    bus.req_i = 1'b0;
    rst = 1'b1;
    step();

    // Pass-through.
    bus.wd_i    = 5'd3;
    bus.wreg_i  = 1'b1;
    bus.wdata_i = 32'h1234;
    #1;
    check("pt_wd",    32'(bus.wd_o),        32'd3);
    check("pt_wreg",  32'(bus.wreg_o),      32'd1);
    check("pt_wdata", bus.wdata_o,          32'h1234);
    check("pt_stall", 32'(bus.stall_req_o), 32'd0);
    check("pt_we",    32'(bus.ram_we_o),    32'd0);
    step();

    // SW 0xDEADBEEF -> 0x200.
    access(1'b1, 2'b10, 1'b0, 5'd9, 32'h200, 32'hDEADBEEF);
    check("sw_stalls", 32'(stalls), 32'd5);
    check("sw_nwr",    32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      e = wlog[i];
      check("sw_addr", e[39:8], 32'h200 + 32'(i));
    end
    if (wlog.size() == 4) begin
      check("sw_b0", 32'(wlog[0][7:0]), 32'hEF);
      check("sw_b1", 32'(wlog[1][7:0]), 32'hBE);
      check("sw_b2", 32'(wlog[2][7:0]), 32'hAD);
      check("sw_b3", 32'(wlog[3][7:0]), 32'hDE);
    end
    check("sw_wreg",  32'(d_wreg), 32'd0);
    check("sw_wd",    32'(d_wd),   32'd0);
    check("sw_wdata", d_wdata,     32'd0);
    check("sw_dstall", 32'(d_stall), 32'd0);
    #1;
    check("done_pulse", 32'(bus.done_o), 32'd0);

    // Preload 0x100..0x103 = 11,22,33,44, then LW.
    access(1'b1, 2'b10, 1'b0, 5'd0, 32'h100, 32'h44332211);
    access(1'b0, 2'b10, 1'b0, 5'd5, 32'h100, 32'd0);
    check("lw_stalls", 32'(stalls), 32'd6);
    check("lw_wdata",  d_wdata,     32'h44332211);
    check("lw_wd",     32'(d_wd),   32'd5);
    check("lw_wreg",   32'(d_wreg), 32'd1);
    check("lw_mis",    32'(d_mis),  32'd0);
    check("lw_nwr",    32'(wlog.size()), 32'd0);

    // Byte: RAM[0x80]=0x80.
    access(1'b1, 2'b00, 1'b0, 5'd0, 32'h80, 32'hFFFFFF80);
    check("sb_stalls", 32'(stalls), 32'd2);
    access(1'b0, 2'b00, 1'b0, 5'd6, 32'h80, 32'd0);
    check("lb_stalls", 32'(stalls), 32'd3);
    check("lb_wdata",  d_wdata,     32'hFFFFFF80);
    access(1'b0, 2'b00, 1'b1, 5'd6, 32'h80, 32'd0);
    check("lbu_wdata", d_wdata,     32'h00000080);

    // Half: RAM[0x90..0x91]=01,80.
    access(1'b1, 2'b01, 1'b0, 5'd0, 32'h90, 32'h00008001);
    check("sh_stalls", 32'(stalls), 32'd3);
    access(1'b0, 2'b01, 1'b0, 5'd7, 32'h90, 32'd0);
    check("lh_stalls", 32'(stalls), 32'd4);
    check("lh_wdata",  d_wdata,     32'hFFFF8001);
    access(1'b0, 2'b01, 1'b1, 5'd7, 32'h90, 32'd0);
    check("lhu_wdata", d_wdata,     32'h00008001);

    // Misaligned LW at 0x102 (0x104..0x107 = 55,66,77,88).
    access(1'b1, 2'b10, 1'b0, 5'd0, 32'h104, 32'h88776655);
    access(1'b0, 2'b10, 1'b0, 5'd8, 32'h102, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_stalls", 32'(stalls), 32'd1);
    check("mis_flag",   32'(d_mis),  32'd1);
    check("mis_wreg",   32'(d_wreg), 32'd0);
`else
    check("mis_stalls", 32'(stalls), 32'd6);
    check("mis_wdata",  d_wdata,     32'h66554433);
    check("mis_wreg",   32'(d_wreg), 32'd1);
    check("mis_flag",   32'(d_mis),  32'd0);
`endif

    // SH 0xBBAA at 0xFFFFFFFF: wraps to 0x0 unless trapped.
    access(1'b1, 2'b01, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0000BBAA);
`ifdef MEM_MISALIGN_TRAP_EN
    check("wrap_nwr",  32'(wlog.size()), 32'd0);
    check("wrap_mis",  32'(d_mis),       32'd1);
`else
    check("wrap_nwr",  32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("wrap_a0", wlog[0][39:8], 32'hFFFFFFFF);
      check("wrap_d0", 32'(wlog[0][7:0]), 32'hAA);
      check("wrap_a1", wlog[1][39:8], 32'h00000000);
      check("wrap_d1", 32'(wlog[1][7:0]), 32'hBB);
    end
`endif

    // Reset mid-store: 0x300..0x303 pre-filled with A5.
    access(1'b1, 2'b10, 1'b0, 5'd0, 32'h300, 32'hA5A5A5A5);
    bus.req_i        = 1'b1;
    bus.we_i         = 1'b1;
    bus.size_i       = 2'b10;
    bus.wreg_i       = 1'b1;
    bus.wd_i         = 5'd4;
    bus.wdata_i      = 32'h300;
    bus.mem_w_data_i = 32'h44332211;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    check("mrst_we",    32'(bus.ram_we_o),    32'd0);
    check("mrst_addr",  bus.ram_addr_o,       32'd0);
    check("mrst_stall", 32'(bus.stall_req_o), 32'd0);
    check("mrst_wreg",  32'(bus.wreg_o),      32'd0);
    check("mrst_done",  32'(bus.done_o),      32'd0);
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.wreg_i  = 1'b0;
    bus.wdata_i = 32'd0;
    step();
    rst = 1'b1;
    step();
    #1;
    check("mrst_m300", 32'(mem[12'h300]), 32'h11);
    check("mrst_m301", 32'(mem[12'h301]), 32'h22);
    check("mrst_m302", 32'(mem[12'h302]), 32'hA5);
    check("mrst_m303", 32'(mem[12'h303]), 32'hA5);
    check("mrst_idle", 32'(bus.stall_req_o), 32'd0);
    access(1'b0, 2'b10, 1'b0, 5'd2, 32'h300, 32'd0);
    check("post_lw", d_wdata, 32'hA5A52211);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
